rram_read_seq: RTL and testbench

RRAM_READ_SEQ -- requirements
Module: rram_read_seq

---
 rtl/rram_read_seq_pkg.sv | 20 ++
 rtl/rram_read_seq_pulse_cnt.sv | 25 ++
 rtl/rram_read_seq.sv | 122 ++++++++++++
 tb/tb_rram_read_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rram_read_seq_pkg.sv
// Shared rram package: read-sequencer state encoding and timing-counter width.
// WORD_SIZE / ADDR_BITS_N normally come from the global defines; fallbacks keep the slice standalone.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif
`ifndef ADDR_BITS_N
`define ADDR_BITS_N 8
`endif

package rram_read_seq_pkg;
   localparam int CNT_W_DEFAULT = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SENSE = 3'd2,
      WAIT  = 3'd3,
      RESP  = 3'd4
   } rram_state_e;
endpackage

// File: rtl/rram_read_seq_pulse_cnt.sv
// Loadable down-counter for SETUP/SENSE/WAIT timing. done marks the last cycle of a phase;
// a load value of 0 never raises done, which gives the "wait forever" behaviour.
module rram_pulse_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign done = (cnt == W'(1));
endmodule

// File: rtl/rram_read_seq.sv
// RRAM read sequencer: drives wordline/select/bitline enables and the sense amp for one word
// read, then returns the sensed word (or a timeout flag) on a response handshake.
module rram_read_seq
   import rram_read_seq_pkg::*;
#(
   parameter int WORD_SIZE   = `WORD_SIZE,
   parameter int ADDR_BITS_N = `ADDR_BITS_N,
   parameter int CNT_W       = CNT_W_DEFAULT
) (
   input  logic                   mclk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [ADDR_BITS_N-1:0] req_addr,
   input  logic [CNT_W-1:0]       cfg_setup,
   input  logic [CNT_W-1:0]       cfg_pw,
   input  logic [CNT_W-1:0]       cfg_timeout,
   output logic [ADDR_BITS_N-1:0] rram_addr,
   output logic                   wl_en,
   output logic                   sl_en,
   output logic                   bl_en,
   output logic                   sa_en,
   output logic                   sa_clk,
   input  logic [WORD_SIZE-1:0]   sa_do,
   input  logic                   sa_rdy,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [WORD_SIZE-1:0]   rsp_data,
   output logic                   rsp_timeout,
   output rram_state_e            dbg_state
);
   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
   // The producer holds valid and its payload stable until that edge; ready never waits on valid.

   rram_state_e    state, next_state;
   logic [CNT_W-1:0] pw_q, tmo_q;
   logic           cnt_load, cnt_done, accept;
   logic [CNT_W-1:0] cnt_val;

   assign accept    = (state == IDLE) && req_valid && req_ready;
   assign dbg_state = state;

   rram_pulse_cnt #(.W(CNT_W)) u_cnt (
      .clk      (mclk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .done     (cnt_done)
   );

   always_ff @(posedge mclk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      cnt_load   = 1'b0;
      cnt_val    = '0;
      case (state)
         IDLE: if (req_valid && req_ready) begin
            next_state = SETUP;
            cnt_load   = 1'b1;
            cnt_val    = (cfg_setup == '0) ? CNT_W'(1) : cfg_setup;
         end
         SETUP: if (cnt_done) begin
            next_state = SENSE;
            cnt_load   = 1'b1;
            cnt_val    = (pw_q == '0) ? CNT_W'(1) : pw_q;
         end
         SENSE: if (cnt_done) begin
            next_state = WAIT;
            cnt_load   = 1'b1;
            cnt_val    = tmo_q;
         end
         WAIT:    if (sa_rdy || cnt_done) next_state = RESP;
         RESP:    if (rsp_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs are flops decoded from next_state, so they line up with the state register.
   always_ff @(posedge mclk) begin
      if (rst) begin
         req_ready   <= 1'b1;
         rram_addr   <= '0;
         wl_en       <= 1'b0;
         sl_en       <= 1'b0;
         bl_en       <= 1'b0;
         sa_en       <= 1'b0;
         sa_clk      <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_timeout <= 1'b0;
         pw_q        <= '0;
         tmo_q       <= '0;
      end else begin
         req_ready <= (next_state == IDLE);
         wl_en     <= (next_state == SETUP) || (next_state == SENSE);
         sl_en     <= (next_state == SETUP) || (next_state == SENSE);
         bl_en     <= (next_state == SETUP) || (next_state == SENSE);
         sa_en     <= (next_state == SENSE) || (next_state == WAIT);
         sa_clk    <= (next_state == SENSE);
         rsp_valid <= (next_state == RESP);
         if (accept) begin
            rram_addr <= req_addr;
            pw_q      <= cfg_pw;
            tmo_q     <= cfg_timeout;
         end
         // sa_rdy is checked before the timeout so a coincident ready still returns data.
         if (state == WAIT) begin
            if (sa_rdy) begin
               rsp_data    <= sa_do;
               rsp_timeout <= 1'b0;
            end else if (cnt_done) begin
               rsp_data    <= '0;
               rsp_timeout <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_rram_read_seq.sv
// Directed bench for rram_read_seq: vector table of whole read transactions plus
// hand-written reset, abort and response-stall sequences.
module tb_rram_read_seq;
   import rram_read_seq_pkg::*;

   logic                    mclk, rst;
   logic                    req_valid, req_ready;
   logic [`ADDR_BITS_N-1:0] req_addr;
   logic [7:0]              cfg_setup, cfg_pw, cfg_timeout;
   logic [`ADDR_BITS_N-1:0] rram_addr;
   logic                    wl_en, sl_en, bl_en, sa_en, sa_clk;
   logic [`WORD_SIZE-1:0]   sa_do;
   logic                    sa_rdy;
   logic                    rsp_valid, rsp_ready;
   logic [`WORD_SIZE-1:0]   rsp_data;
   logic                    rsp_timeout;
   rram_state_e             dbg_state;

   int total = 0;
   int bad   = 0;

   rram_read_seq dut (
      .mclk(mclk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .cfg_setup(cfg_setup), .cfg_pw(cfg_pw), .cfg_timeout(cfg_timeout),
      .rram_addr(rram_addr), .wl_en(wl_en), .sl_en(sl_en), .bl_en(bl_en),
      .sa_en(sa_en), .sa_clk(sa_clk), .sa_do(sa_do), .sa_rdy(sa_rdy),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_timeout(rsp_timeout), .dbg_state(dbg_state)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   typedef struct {
      logic [7:0] setup, pw, tmo, addr, sdo, exp_data;
      int         rdy_at;   // WAIT-cycle index at which sa_rdy is driven, -1 = never
      int         hold;     // cycles rsp_ready is held low
      int         exp_wl, exp_clk, exp_lat;
      logic       exp_to;
   } vec_t;

   vec_t vecs[8];

   function automatic vec_t mk(input logic [7:0] s, p, t, a, d, input int r, h,
                               input int wl, ck, lat, input logic [7:0] ed, input logic et);
      vec_t v;
      v.setup = s; v.pw = p; v.tmo = t; v.addr = a; v.sdo = d; v.rdy_at = r; v.hold = h;
      v.exp_wl = wl; v.exp_clk = ck; v.exp_lat = lat; v.exp_data = ed; v.exp_to = et;
      return v;
   endfunction

   task automatic step();
      @(posedge mclk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic run_txn(input vec_t v, input int idx);
      int wl, ck, lat, split, addr_bad, rr_bad, wcnt;
      bit got;
      logic [7:0] held;
      wl = 0; ck = 0; lat = 0; split = 0; addr_bad = 0; rr_bad = 0; wcnt = 0; got = 0;
      check($sformatf("v%0d_req_ready_idle", idx), req_ready, 1);
      req_valid = 1'b1; req_addr = v.addr;
      cfg_setup = v.setup; cfg_pw = v.pw; cfg_timeout = v.tmo;
      step();
      req_valid = 1'b0;
      req_addr = 8'($urandom);
      cfg_setup = 8'($urandom_range(0, 255));
      cfg_pw = 8'($urandom_range(0, 255));
      cfg_timeout = 8'($urandom_range(1, 255));
      for (int c = 1; c <= 200; c++) begin
         if (rsp_valid) begin
            lat = c; got = 1;
            break;
         end
         if (wl_en) wl++;
         if (sa_clk) ck++;
         if (wl_en !== sl_en || wl_en !== bl_en) split++;
         if (wl_en && rram_addr !== v.addr) addr_bad++;
         if (req_ready) rr_bad++;
         if (wl_en) begin
            sa_rdy = 1'b1; sa_do = 8'h3C;
         end else if (sa_en) begin
            sa_rdy = (wcnt == v.rdy_at);
            sa_do  = sa_rdy ? v.sdo : 8'($urandom);
            wcnt++;
         end else begin
            sa_rdy = 1'b0;
         end
         step();
      end
      sa_rdy = 1'b0;
      check($sformatf("v%0d_rsp_seen", idx), got, 1);
      check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
      check($sformatf("v%0d_wl_cycles", idx), wl, v.exp_wl);
      check($sformatf("v%0d_saclk_cycles", idx), ck, v.exp_clk);
      check($sformatf("v%0d_wl_sl_bl_split", idx), split, 0);
      check($sformatf("v%0d_rram_addr", idx), addr_bad, 0);
      check($sformatf("v%0d_req_ready_busy", idx), rr_bad, 0);
      check($sformatf("v%0d_rsp_data", idx), rsp_data, v.exp_data);
      check($sformatf("v%0d_rsp_timeout", idx), rsp_timeout, v.exp_to);
      if (!got) begin
         do_reset();
      end else begin
         held = rsp_data;
         for (int h = 0; h < v.hold; h++) begin
            sa_do = 8'($urandom); sa_rdy = 1'($urandom_range(0, 1));
            step();
            check($sformatf("v%0d_hold_valid", idx), rsp_valid, 1);
            check($sformatf("v%0d_hold_data", idx), rsp_data, v.exp_data);
            check($sformatf("v%0d_hold_req_ready", idx), req_ready, 0);
            check($sformatf("v%0d_hold_ctl", idx), {wl_en, sl_en, bl_en, sa_en, sa_clk}, 0);
         end
         sa_rdy = 1'b0;
         rsp_ready = 1'b1;
         step();
         rsp_ready = 1'b0;
         check($sformatf("v%0d_rsp_done", idx), rsp_valid, 0);
         check($sformatf("v%0d_req_ready_back", idx), req_ready, 1);
         check($sformatf("v%0d_addr_held", idx), rram_addr, v.addr);
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
      cfg_setup = 8'd0; cfg_pw = 8'd0; cfg_timeout = 8'd0; sa_do = '0; sa_rdy = 1'b0;

      //          setup  pw    tmo   addr   sa_do  rdy hold wl clk lat  data   to
      vecs[0] = mk(8'd2, 8'd3, 8'd0, 8'h15, 8'hA5,  2, 10,  5, 3,  9, 8'hA5, 1'b0);
      vecs[1] = mk(8'd1, 8'd1, 8'd4, 8'h2A, 8'h11, -1,  2,  2, 1,  7, 8'h00, 1'b1);
      vecs[2] = mk(8'd0, 8'd0, 8'd0, 8'h01, 8'h5A,  0,  0,  2, 1,  4, 8'h5A, 1'b0);
      vecs[3] = mk(8'd1, 8'd1, 8'd1, 8'hFF, 8'h0F,  0,  1,  2, 1,  4, 8'h0F, 1'b0);
      vecs[4] = mk(8'd1, 8'd2, 8'd3, 8'h40, 8'hC3,  2,  0,  3, 2,  7, 8'hC3, 1'b0);
      vecs[5] = mk(8'd3, 8'd1, 8'd1, 8'h33, 8'hEE, -1,  0,  4, 1,  6, 8'h00, 1'b1);
      vecs[6] = mk(8'd1, 8'd1, 8'd0, 8'h7E, 8'h77, 20,  0,  2, 1, 24, 8'h77, 1'b0);
      vecs[7] = mk(8'd0, 8'd5, 8'd2, 8'h80, 8'h99,  1,  0,  6, 5,  9, 8'h99, 1'b0);

      step();
      step();
      check("rst_ctl", {wl_en, sl_en, bl_en, sa_en, sa_clk}, 0);
      check("rst_rram_addr", rram_addr, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_timeout", rsp_timeout, 0);
      check("rst_state", dbg_state, IDLE);
      rst = 1'b0;
      step();
      check("rst_req_ready", req_ready, 1);

      for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

      // Abort in SENSE: reset must drop every control and never produce a response.
      req_valid = 1'b1; req_addr = 8'h5C; cfg_setup = 8'd1; cfg_pw = 8'd5; cfg_timeout = 8'd0;
      step();
      req_valid = 1'b0;
      for (int c = 0; c < 10 && !sa_clk; c++) step();
      check("abort_in_sense", sa_clk, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_ctl", {wl_en, sl_en, bl_en, sa_en, sa_clk}, 0);
      check("abort_req_ready", req_ready, 1);
      check("abort_rsp_valid", rsp_valid, 0);
      check("abort_rsp_data", rsp_data, 0);
      check("abort_rram_addr", rram_addr, 0);
      for (int c = 0; c < 5; c++) begin
         sa_rdy = 1'b1; sa_do = 8'($urandom);
         step();
         check("abort_quiet", {rsp_valid, wl_en, sa_en}, 0);
      end
      sa_rdy = 1'b0;
      run_txn(vecs[0], 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
